// File: rtl/z80_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_pkg
//  Description : Shared types and constants for the tv80s bus responder:
//                bus-cycle classification, responder FSM states, helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package z80_bus_pkg;

  // Bus cycle kinds recognised at cycle start
  typedef enum logic [2:0] {
    CYC_NONE  = 3'd0,
    CYC_M1    = 3'd1,
    CYC_MEMRD = 3'd2,
    CYC_MEMWR = 3'd3,
    CYC_IORD  = 3'd4,
    CYC_IOWR  = 3'd5,
    CYC_INTA  = 3'd6
  } cyc_e;

  // Responder FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  // Value presented on di out of reset
  localparam logic [7:0] DI_RESET = 8'hFF;

  // Cycle kinds that return a byte to the CPU on di
  function automatic logic cyc_is_read(input cyc_e c);
    return (c == CYC_M1) || (c == CYC_MEMRD) || (c == CYC_IORD) || (c == CYC_INTA);
  endfunction

  // Cycle kinds framed by iorq_n rather than mreq_n
  function automatic logic cyc_is_io(input cyc_e c);
    return (c == CYC_IORD) || (c == CYC_IOWR) || (c == CYC_INTA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_bus_responder_decode.sv
`default_nettype none
// ============================================================================
//  Module      : z80_cycle_decode
//  Description : Combinational classifier from the Z80 strobes to a cycle
//                kind plus an illegal-combination flag. Refresh is NONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_cycle_decode
  import z80_bus_pkg::*;
(
  input  logic m1_n_i,
  input  logic mreq_n_i,
  input  logic iorq_n_i,
  input  logic rd_n_i,
  input  logic wr_n_i,
  input  logic rfsh_n_i,
  output cyc_e cyc_o,
  output logic illegal_o
);

  logic w_illegal;

  // Both address spaces at once, or both directions at once, is never valid
  assign w_illegal = (!mreq_n_i && !iorq_n_i) || (!rd_n_i && !wr_n_i);
  assign illegal_o = w_illegal;

  // Classify the strobe pattern; anything unrecognised stays CYC_NONE
  always_comb begin
    cyc_o = CYC_NONE;
    if (!w_illegal) begin
      if (!mreq_n_i) begin
        // mreq with rfsh low is a refresh cycle and is ignored
        if (rfsh_n_i) begin
          if (!rd_n_i) begin
            cyc_o = m1_n_i ? CYC_MEMRD : CYC_M1;
          end else if (!wr_n_i) begin
            cyc_o = CYC_MEMWR;
          end
        end
      end else if (!iorq_n_i) begin
        if (!m1_n_i) begin
          cyc_o = CYC_INTA;
        end else if (!rd_n_i) begin
          cyc_o = CYC_IORD;
        end else if (!wr_n_i) begin
          cyc_o = CYC_IOWR;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_responder
//  Description : Slave end of the tv80s memory/IO bus. Decodes CPU cycles,
//                issues single-clock requests to a backing store and an IO
//                port, inserts wait states and returns read data on di.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned WAIT_M1  = 0,
  parameter int unsigned WAIT_MEM = 0,
  parameter int unsigned WAIT_IO  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  input  logic [7:0]  int_vec,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_re,
  output logic        io_we,
  input  logic [7:0]  io_rdata,
  output logic [15:0] fetch_cnt,
  output logic        bus_err
);

  localparam logic [2:0] c_wait_m1  = 3'(WAIT_M1);
  localparam logic [2:0] c_wait_mem = 3'(WAIT_MEM);
  localparam logic [2:0] c_wait_io  = 3'(WAIT_IO);

  state_e      state_q,     state_d;
  cyc_e        cyc_q,       cyc_d;
  logic [2:0]  wcnt_q,      wcnt_d;
  logic        wait_n_q,    wait_n_d;
  logic        load_q,      load_d;
  logic        post_rst_q,  post_rst_d;
  logic [7:0]  di_q,        di_d;
  logic [15:0] mem_addr_q,  mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_re_q,    mem_re_d;
  logic        mem_we_q,    mem_we_d;
  logic [7:0]  io_addr_q,   io_addr_d;
  logic [7:0]  io_wdata_q,  io_wdata_d;
  logic        io_re_q,     io_re_d;
  logic        io_we_q,     io_we_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic        bus_err_q,   bus_err_d;

  cyc_e        w_cyc;
  logic        w_illegal;
  logic [2:0]  w_wait;
  logic        w_strobe_active;
  logic        w_strobe_released;

  z80_cycle_decode u_decode (
    .m1_n_i    (m1_n),
    .mreq_n_i  (mreq_n),
    .iorq_n_i  (iorq_n),
    .rd_n_i    (rd_n),
    .wr_n_i    (wr_n),
    .rfsh_n_i  (rfsh_n),
    .cyc_o     (w_cyc),
    .illegal_o (w_illegal)
  );

  assign w_strobe_active   = !mreq_n || !iorq_n;
  // The strobe framing the current cycle: iorq_n for IO/INTA, else mreq_n
  assign w_strobe_released = cyc_is_io(cyc_q) ? iorq_n : mreq_n;

  // Wait-state count for the cycle being started
  always_comb begin
    w_wait = c_wait_io;
    case (w_cyc)
      CYC_M1:              w_wait = c_wait_m1;
      CYC_MEMRD, CYC_MEMWR: w_wait = c_wait_mem;
      default:             w_wait = c_wait_io;
    endcase
  end

  // Next-state, request pulses, wait countdown and read-data capture
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    wcnt_d      = wcnt_q;
    wait_n_d    = wait_n_q;
    load_d      = 1'b0;
    post_rst_d  = post_rst_q;
    di_d        = di_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    io_re_d     = 1'b0;
    io_we_d     = 1'b0;
    fetch_cnt_d = fetch_cnt_q;
    bus_err_d   = bus_err_q;

    // Read data lands one clock after the request, independent of waits
    if (load_q) begin
      case (cyc_q)
        CYC_M1, CYC_MEMRD: di_d = mem_rdata;
        CYC_IORD:          di_d = io_rdata;
        CYC_INTA:          di_d = int_vec;
        default:           di_d = di_q;
      endcase
    end

    // wait_n releases on the edge that consumes the last wait state
    if (wcnt_q != 3'd0) begin
      wcnt_d = wcnt_q - 3'd1;
      if (wcnt_q == 3'd1) begin
        wait_n_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        post_rst_d = 1'b0;
        if (post_rst_q && w_strobe_active) begin
          // A cycle that straddled reset is never serviced
          state_d = S_DRAIN;
        end else if (w_illegal) begin
          bus_err_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (w_cyc != CYC_NONE) begin
          state_d  = S_ACCESS;
          cyc_d    = w_cyc;
          wcnt_d   = w_wait;
          wait_n_d = (w_wait == 3'd0);
          case (w_cyc)
            CYC_M1: begin
              mem_addr_d  = A;
              mem_re_d    = 1'b1;
              fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
            CYC_MEMRD: begin
              mem_addr_d = A;
              mem_re_d   = 1'b1;
            end
            CYC_MEMWR: begin
              mem_addr_d  = A;
              mem_wdata_d = dout;
              mem_we_d    = 1'b1;
            end
            CYC_IORD: begin
              io_addr_d = A[7:0];
              io_re_d   = 1'b1;
            end
            CYC_IOWR: begin
              io_addr_d  = A[7:0];
              io_wdata_d = dout;
              io_we_d    = 1'b1;
            end
            default: begin
              // INTA: no request, vector returned through the load path
            end
          endcase
        end
      end
      S_ACCESS: begin
        load_d  = cyc_is_read(cyc_q);
        state_d = (wcnt_q > 3'd1) ? S_WAIT : S_HOLD;
      end
      S_WAIT: begin
        if (wcnt_q <= 3'd1) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_strobe_released) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mreq_n && iorq_n) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= CYC_NONE;
      wcnt_q      <= 3'd0;
      wait_n_q    <= 1'b1;
      load_q      <= 1'b0;
      post_rst_q  <= 1'b1;
      di_q        <= DI_RESET;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      io_addr_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
      io_re_q     <= 1'b0;
      io_we_q     <= 1'b0;
      fetch_cnt_q <= 16'h0000;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      wcnt_q      <= wcnt_d;
      wait_n_q    <= wait_n_d;
      load_q      <= load_d;
      post_rst_q  <= post_rst_d;
      di_q        <= di_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      io_re_q     <= io_re_d;
      io_we_q     <= io_we_d;
      fetch_cnt_q <= fetch_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign di        = di_q;
  assign wait_n    = wait_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign io_re     = io_re_q;
  assign io_we     = io_we_q;
  assign fetch_cnt = fetch_cnt_q;
  assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_z80_bus_responder
//  Description : Self-checking bench: directed and random CPU bus cycles
//                against a cycle-level reference model of the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_bus_responder;

  localparam int unsigned P_WAIT_M1  = 0;
  localparam int unsigned P_WAIT_MEM = 2;
  localparam int unsigned P_WAIT_IO  = 3;

  localparam int K_M1 = 0, K_MEMRD = 1, K_MEMWR = 2, K_IORD = 3, K_IOWR = 4, K_INTA = 5;

  logic        clk = 1'b0;
  logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout, int_vec;
  logic [7:0]  di, mem_wdata, io_addr, io_wdata;
  logic        wait_n, mem_re, mem_we, io_re, io_we, bus_err;
  logic [15:0] mem_addr, fetch_cnt;
  logic [7:0]  mem_rdata, io_rdata;

  always #5 clk = ~clk;

  z80_bus_responder #(
    .WAIT_M1  (P_WAIT_M1),
    .WAIT_MEM (P_WAIT_MEM),
    .WAIT_IO  (P_WAIT_IO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m1_n      (m1_n),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .rfsh_n    (rfsh_n),
    .A         (A),
    .dout      (dout),
    .di        (di),
    .wait_n    (wait_n),
    .int_vec   (int_vec),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_re     (io_re),
    .io_we     (io_we),
    .io_rdata  (io_rdata),
    .fetch_cnt (fetch_cnt),
    .bus_err   (bus_err)
  );

  // Backing store and IO device attached to the responder
  bit   [7:0]  dev_mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  io_val;

  always @(posedge clk) begin
    if (pl_we)  dev_mem[pl_addr] <= pl_data;
    if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= dev_mem[mem_addr];
    if (io_re)  io_rdata <= io_val;
  end

  // Running totals of request pulses and wait clocks, one sample per clock
  int unsigned tot_mre = 0, tot_mwe = 0, tot_ire = 0, tot_iwe = 0, tot_wait = 0;
  always @(negedge clk) begin
    if (mem_re === 1'b1) tot_mre++;
    if (mem_we === 1'b1) tot_mwe++;
    if (io_re === 1'b1)  tot_ire++;
    if (io_we === 1'b1)  tot_iwe++;
    if (wait_n === 1'b0) tot_wait++;
  end

  // Reference model state
  bit   [7:0]  ref_mem [0:65535];
  logic [7:0]  exp_di;
  logic [15:0] exp_fetch;
  logic        exp_err;

  int n_vec = 0;
  int n_err = 0;
  int unsigned s_mre, s_mwe, s_ire, s_iwe, s_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_mre = tot_mre; s_mwe = tot_mwe; s_ire = tot_ire; s_iwe = tot_iwe; s_wait = tot_wait;
  endtask

  task automatic chk_counts(input string tag, input logic [3:0] req, input int unsigned nw);
    chk({tag, "_pulses"},
        {8'(tot_mre - s_mre), 8'(tot_mwe - s_mwe), 8'(tot_ire - s_ire), 8'(tot_iwe - s_iwe)},
        {7'd0, req[3], 7'd0, req[2], 7'd0, req[1], 7'd0, req[0]});
    chk({tag, "_waits"}, tot_wait - s_wait, nw);
  endtask

  task automatic idle_bus();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic drive(input int k, input logic [15:0] a, input logic [7:0] d);
    idle_bus();
    A = a; dout = d;
    case (k)
      K_M1:    begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
      K_MEMRD: begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MEMWR: begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
      default: begin m1_n = 1'b0; iorq_n = 1'b0; end
    endcase
  endtask

  // One complete bus cycle: drive at a negedge, check request timing,
  // read data two clocks after the start edge, then pulse/wait totals.
  task automatic do_cycle(input int k, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] v, input int unsigned extra, input int unsigned gap);
    int unsigned nw;
    logic [3:0]  req;
    logic        is_mem;
    nw     = (k == K_M1) ? P_WAIT_M1 : ((k == K_MEMRD || k == K_MEMWR) ? P_WAIT_MEM : P_WAIT_IO);
    is_mem = (k == K_M1 || k == K_MEMRD || k == K_MEMWR);
    req    = {(k == K_M1 || k == K_MEMRD), (k == K_MEMWR), (k == K_IORD), (k == K_IOWR)};
    snap();
    io_val = v; int_vec = v;
    drive(k, a, d);
    @(negedge clk);
    if (k == K_M1) exp_fetch = exp_fetch + 16'd1;
    chk("req", {mem_re, mem_we, io_re, io_we}, req);
    chk("wait_n_first", wait_n, (nw == 0));
    chk("fetch_cnt", fetch_cnt, exp_fetch);
    if (is_mem) chk("mem_addr", mem_addr, a);
    else if (k != K_INTA) chk("io_addr", io_addr, a[7:0]);
    if (k == K_MEMWR) begin
      chk("mem_wdata", mem_wdata, d);
      ref_mem[a] = d;
    end
    if (k == K_IOWR) chk("io_wdata", io_wdata, d);
    case (k)
      K_M1, K_MEMRD: exp_di = ref_mem[a];
      K_IORD, K_INTA: exp_di = v;
      default: ;
    endcase
    repeat (2) @(negedge clk);
    chk("di", di, exp_di);
    repeat (nw + extra) @(negedge clk);
    idle_bus();
    repeat (1 + gap) @(negedge clk);
    chk_counts("cycle", req, nw);
    chk("bus_err", bus_err, exp_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [15:0] a;
    idle_bus();
    reset_n = 1'b0; A = 16'h0000; dout = 8'h00; int_vec = 8'h00; io_val = 8'h00;
    pl_we = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;
    exp_di = 8'hFF; exp_fetch = 16'h0000; exp_err = 1'b0;

    // Preload the two opcode bytes
    @(negedge clk);
    pl_we = 1'b1; pl_addr = 16'h0000; pl_data = 8'hCB; ref_mem[16'h0000] = 8'hCB;
    @(negedge clk);
    pl_addr = 16'h0001; pl_data = 8'h5F; ref_mem[16'h0001] = 8'h5F;
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_di", di, 8'hFF);
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_req", {mem_re, mem_we, io_re, io_we}, 4'b0000);
    chk("rst_fetch", fetch_cnt, 16'h0000);
    chk("rst_err", bus_err, 1'b0);
    repeat (2) @(negedge clk);

    // Opcode fetches, write held long, read back
    do_cycle(K_M1, 16'h0000, 8'h00, 8'h00, 0, 0);
    do_cycle(K_M1, 16'h0001, 8'h00, 8'h00, 0, 1);
    chk("fetch_two", fetch_cnt, 16'd2);
    do_cycle(K_MEMWR, 16'h6133, 8'h90, 8'h00, 3, 0);
    do_cycle(K_MEMRD, 16'h6133, 8'h00, 8'h00, 0, 0);
    chk("rd_6133", di, 8'h90);
    do_cycle(K_IORD, 16'h1234, 8'h00, 8'h5A, 0, 1);
    do_cycle(K_INTA, 16'h0000, 8'h00, 8'h38, 1, 0);
    chk("inta_di", di, 8'h38);

    // Refresh cycle: no request, no state change
    snap();
    mreq_n = 1'b0; rfsh_n = 1'b0; A = 16'h0042;
    repeat (3) @(negedge clk);
    chk("rfsh_req", {mem_re, mem_we, io_re, io_we}, 4'b0000);
    idle_bus();
    @(negedge clk);
    chk_counts("rfsh", 4'b0000, 0);
    chk("rfsh_fetch", fetch_cnt, exp_fetch);

    // Random cycles
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 5));
      a = (k == K_IORD || k == K_IOWR) ? 16'($urandom) : {12'h610, 4'($urandom_range(0, 7))};
      do_cycle(k, a, 8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 1));
    end

    // Illegal strobe combination: sticky error, drain until both strobes high
    snap();
    idle_bus();
    mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; A = 16'h6101;
    @(negedge clk);
    exp_err = 1'b1;
    chk("ill_err", bus_err, 1'b1);
    chk("ill_req", {mem_re, mem_we, io_re, io_we}, 4'b0000);
    repeat (2) @(negedge clk);
    iorq_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ill_drain_req", {mem_re, mem_we, io_re, io_we}, 4'b0000);
    idle_bus();
    repeat (2) @(negedge clk);
    chk_counts("ill", 4'b0000, 0);
    chk("ill_sticky", bus_err, 1'b1);
    do_cycle(K_MEMWR, 16'h6140, 8'h3C, 8'h00, 0, 0);

    // Reset asserted with a write cycle on the bus
    snap();
    reset_n = 1'b0;
    drive(K_MEMWR, 16'h6133, 8'h11);
    @(negedge clk);
    reset_n = 1'b1;
    exp_di = 8'hFF; exp_fetch = 16'h0000; exp_err = 1'b0;
    chk("rr_di", di, 8'hFF);
    chk("rr_wait_n", wait_n, 1'b1);
    chk("rr_req", {mem_re, mem_we, io_re, io_we}, 4'b0000);
    chk("rr_addr", {mem_addr, io_addr}, 24'h000000);
    chk("rr_wdata", {mem_wdata, io_wdata}, 16'h0000);
    chk("rr_fetch", fetch_cnt, 16'h0000);
    chk("rr_err", bus_err, 1'b0);
    repeat (4) @(negedge clk);
    idle_bus();
    repeat (2) @(negedge clk);
    chk_counts("rr", 4'b0000, 0);
    do_cycle(K_MEMRD, 16'h6133, 8'h00, 8'h00, 0, 0);
    do_cycle(K_M1, 16'h0001, 8'h00, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synthesizable responder for the tv80s Z80 bus: the slave end of the CPU's memory/IO bus.
- Decodes opcode fetch, memory read/write, IO read/write, interrupt-acknowledge and refresh cycles from the CPU strobes.
- Drives `di` and `wait_n` back to the CPU.
- Turns each qualified cycle into single-cycle read/write requests on a backing-store port and an IO port.
- Replaces behavioural bus models in CPU-level benches and FPGA tops.

## Interface
Parameters:
- WAIT_M1, 0: wait states inserted on opcode fetch cycles (0–7).
- WAIT_MEM, 0: wait states on non-M1 memory cycles (0–7).
- WAIT_IO, 1: wait states on IO cycles and INTA (0–7).

Ports (clk and reset first):
- clk  in  1  single clock, shared with the CPU; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU strobes.
- A  in  16  CPU address.
- dout  in  8  CPU write data.
- di  out  8  read data to the CPU.
- wait_n  out  1  wait request to the CPU.
- int_vec  in  8  byte returned during INTA.
- mem_addr  out  16, mem_wdata  out  8, mem_re  out  1, mem_we  out  1  backing-store request.
- mem_rdata  in  8  backing-store read data, valid 1 clk after mem_re.
- io_addr  out  8, io_wdata  out  8, io_re  out  1, io_we  out  1  IO request; io_addr = A[7:0].
- io_rdata  in  8  IO read data, valid 1 clk after io_re.
- fetch_cnt  out  16  count of M1 fetch cycles accepted; wraps FFFF->0000.
- bus_err  out  1  sticky; set on illegal strobe combination.

## Operation
States: IDLE, ACCESS, WAIT, HOLD, DRAIN.

Cycle start is detected in IDLE at a rising edge:
- MEMRD: mreq_n=0, rfsh_n=1, rd_n=0. M1 fetch additionally has m1_n=0.
- MEMWR: mreq_n=0, rfsh_n=1, wr_n=0.
- IORD / IOWR: iorq_n=0, m1_n=1, rd_n=0 or wr_n=0 respectively.
- INTA: m1_n=0, iorq_n=0.
- Refresh (mreq_n=0, rfsh_n=0) is ignored. No request issued, state unchanged.

Illegal combinations:
- mreq_n=0 and iorq_n=0 together, or rd_n=0 and wr_n=0 together.
- Response: set bus_err, issue no request, go to DRAIN.

On start, move to ACCESS. A and dout are latched. Exactly one request pulse is issued per cycle:
- MEMRD: mem_re.
- MEMWR: mem_we with mem_wdata=dout.
- IORD / IOWR: io_re / io_we.
- INTA: no request; di loads int_vec.
- M1 fetch: fetch_cnt increments by 1.

Wait states and data:
- WAIT: wait_n=0 for exactly N clocks, where N is the parameter for the cycle type. When N=0, WAIT is skipped.
- ACCESS+1: di loads mem_rdata / io_rdata. di holds until the next read cycle loads it.
- HOLD: remain until the active strobe (mreq_n or iorq_n) is 1, then go to IDLE.
- A write strobe held for many clocks still produces one mem_we/io_we.

DRAIN: wait until mreq_n=1 and iorq_n=1, then go to IDLE.

Reset (reset_n=0 at an edge):
- Reset values: state IDLE, di=FF, wait_n=1, all re/we=0, mem_addr=0, mem_wdata=0, io_addr=0, io_wdata=0, fetch_cnt=0, bus_err=0.
- A cycle in progress is abandoned; no pending write is committed.
- On release, if any strobe is still active, go to DRAIN. A partial cycle is never serviced.

## Timing
- Start edge = E. Request pulse at E+1 (registered), one clock wide.
- Read data: di valid from E+2.
- Wait states: wait_n low during clocks E+1 .. E+N. The fetch/read data path is unaffected by waits.
- Back-to-back: a new cycle is accepted on the first edge in IDLE. The minimum turnaround is one IDLE clock after the strobe rises.
- Simultaneous refresh with a pending HOLD: HOLD exits on mreq_n rising first; the following refresh is ignored.
- fetch_cnt updates at E+1.

## Structure
Shared package `z80_bus_pkg`:
- cycle-type enum {CYC_NONE, CYC_M1, CYC_MEMRD, CYC_MEMWR, CYC_IORD, CYC_IOWR, CYC_INTA}.
- FSM state enum.
- Reset constant DI_RESET=8'hFF.

Sub-module `z80_cycle_decode`: combinational classifier from strobes to cycle type plus illegal flag. The FSM, wait counter (3 bits) and output registers live in the top.

## Test plan
- Preload mem[0000]=CB, mem[0001]=5F, reset, drive an M1 fetch at 0000 then 0001 -> di=CB then 5F; fetch_cnt=2; no mem_we.
- MEMWR A=6133, dout=90, wr_n held 3 clocks -> exactly one mem_we, mem_addr=6133, mem_wdata=90; then MEMRD 6133 -> di=90.
- IORD A=0x1234 with WAIT_IO=3, io_rdata=5A -> io_addr=34, wait_n low exactly 3 clocks, di=5A.
- INTA with int_vec=38 -> di=38, no mem_re/io_re; a following refresh cycle (mreq_n=0, rfsh_n=0) -> no request.
- mreq_n=0 and iorq_n=0 together -> bus_err=1 and stays 1; no requests until both strobes are high.
- reset_n=0 for one clock in the middle of MEMWR (wr_n still low) -> no mem_we, all outputs at reset values, DRAIN until mreq_n=1.
